// File: rtl/config_chain_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
// Optional feature macro used by the loader: CONFIG_CHAIN_LOADER_CHECKSUM_EN.
package config_chain_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        CHECK  = 3'd3,
        COMMIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Number of words needed to cover the chain (ceiling division)
    function automatic int unsigned calc_nwords(input int unsigned chain_len,
                                                input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits taken from the LSBs of the final word
    function automatic int unsigned calc_last_bits(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return chain_len - (calc_nwords(chain_len, word_w) - 1) * word_w;
    endfunction

    localparam int unsigned DEFAULT_CHAIN_LEN = 40;
    localparam int unsigned DEFAULT_WORD_W    = 8;
    localparam int unsigned DEFAULT_LAST_BITS = calc_last_bits(DEFAULT_CHAIN_LEN, DEFAULT_WORD_W);

endpackage

// File: rtl/config_word_serializer.sv
// Serialises one captured word LSB-first, presenting a registered bit and
// valid flag, and flags the last bit of the requested bit count.
module config_word_serializer #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic [CNT_W-1:0]  nbits,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              last_c
);

    logic [WORD_W-1:0] sreg;
    logic [CNT_W-1:0]  rem;

    // Capture register plus remaining-bit counter; bit_out is forced low when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            rem       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else if (load) begin
            bit_out   <= data[0];
            bit_valid <= 1'b1;
            sreg      <= data >> 1;
            rem       <= nbits - CNT_W'(1);
        end else if (bit_valid) begin
            if (rem != '0) begin
                bit_out <= sreg[0];
                sreg    <= sreg >> 1;
                rem     <= rem - CNT_W'(1);
            end else begin
                bit_out   <= 1'b0;
                bit_valid <= 1'b0;
            end
        end
    end

    assign last_c = bit_valid && (rem == '0);

endmodule

// File: rtl/config_chain_loader.sv
// Loads configuration words into the serial mux-selector chain and issues a
// single commit pulse once the whole chain has been filled.
// Optional feature: define CONFIG_CHAIN_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum word; a mismatch suppresses the commit and raises error.
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned WORD_W    = DEFAULT_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_shift_data,
    output logic              cfg_shift_en,
    output logic              cfg_commit,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned LAST_BITS = calc_last_bits(CHAIN_LEN, WORD_W);
    localparam int unsigned CNT_W     = $clog2(WORD_W + 1);
    localparam int unsigned BIT_CNT_W = $clog2(CHAIN_LEN + 1);

    state_t               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 last_word;
    logic                 accept_c;
    logic                 final_word_c;
    logic                 ser_last_c;
    logic [CNT_W-1:0]     word_bits_c;

`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]    csum;
    logic                 err_q;
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    // All preceding words are full, so the final word starts at CHAIN_LEN-LAST_BITS
    assign accept_c     = (state == LOAD) && s_valid && s_ready;
    assign final_word_c = (bit_cnt == BIT_CNT_W'(CHAIN_LEN - LAST_BITS));
    assign word_bits_c  = final_word_c ? CNT_W'(LAST_BITS) : CNT_W'(WORD_W);

    config_word_serializer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_c),
        .data      (s_data),
        .nbits     (word_bits_c),
        .bit_out   (cfg_shift_data),
        .bit_valid (cfg_shift_en),
        .last_c    (ser_last_c)
    );

    // Load sequencer with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            cfg_commit <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_cnt    <= '0;
            last_word  <= 1'b0;
`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
            csum       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            cfg_commit <= 1'b0;
            if (cfg_shift_en && (bit_cnt != BIT_CNT_W'(CHAIN_LEN))) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        s_ready   <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        bit_cnt   <= '0;
                        last_word <= 1'b0;
`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
                        csum      <= '0;
                        err_q     <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        state     <= SHIFT;
                        s_ready   <= 1'b0;
                        last_word <= final_word_c;
`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
                        csum      <= csum ^ s_data;
`endif
                    end
                end
                SHIFT: begin
                    if (ser_last_c) begin
                        if (!last_word) begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end else begin
`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
                            state   <= CHECK;
                            s_ready <= 1'b1;
`else
                            state      <= COMMIT;
                            cfg_commit <= 1'b1;
`endif
                        end
                    end
                end
`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (s_valid && s_ready) begin
                        s_ready <= 1'b0;
                        if (s_data == csum) begin
                            state      <= COMMIT;
                            cfg_commit <= 1'b1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                COMMIT: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader (CHAIN_LEN=20/WORD_W=8 plus an
// exact-fit CHAIN_LEN=16 instance). Honours CONFIG_CHAIN_LOADER_CHECKSUM_EN.
module tb_config_chain_loader;

    localparam int unsigned CL = 20;
    localparam int unsigned WW = 8;
`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready, cfg_shift_data, cfg_shift_en, cfg_commit, busy, done, error;

    logic       start2;
    logic [7:0] s_data2;
    logic       s_valid2;
    logic       s_ready2, cfg_shift_data2, cfg_shift_en2, cfg_commit2, busy2, done2, error2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .cfg_shift_data(cfg_shift_data), .cfg_shift_en(cfg_shift_en),
        .cfg_commit(cfg_commit), .busy(busy), .done(done), .error(error)
    );

    config_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_fit (
        .clk(clk), .rst(rst), .start(start2), .s_data(s_data2), .s_valid(s_valid2),
        .s_ready(s_ready2), .cfg_shift_data(cfg_shift_data2), .cfg_shift_en(cfg_shift_en2),
        .cfg_commit(cfg_commit2), .busy(busy2), .done(done2), .error(error2)
    );

    typedef struct {
        logic [2:0][7:0] words;
        int              stall;
        bit              start_mid;
        logic [7:0]      csum;
        logic [19:0]     exp_bits;
        bit              exp_err;
    } vec_t;

    vec_t vecs[6];

    // Scoreboard of expected chain bits and monitor bookkeeping
    logic exp_q[$];
    logic mon_bit;
    int   cyc = 0;
    int   shift_total = 0;
    int   commit_cnt = 0;
    int   last_shift_cyc = 0;
    int   commit_cyc = 0;
    int   done_rise_cyc = 0;
    logic done_q = 1'b0;

    // Output monitor: pops expected bits on each shift cycle
    always @(negedge clk) begin
        cyc++;
        if (cfg_shift_en) begin
            last_shift_cyc = cyc;
            shift_total++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL shift_extra cycle=%0d actual_data=%0b required=no_shift", cyc, cfg_shift_data);
            end else begin
                mon_bit = exp_q.pop_front();
                if (cfg_shift_data !== mon_bit) begin
                    failures++;
                    $display("FAIL shift_bit cycle=%0d actual=%0b required=%0b", cyc, cfg_shift_data, mon_bit);
                end
            end
        end else begin
            checks++;
            if (cfg_shift_data !== 1'b0) begin
                failures++;
                $display("FAIL idle_data cycle=%0d actual=%0b required=0", cyc, cfg_shift_data);
            end
        end
        if (cfg_commit) begin
            commit_cnt++;
            commit_cyc = cyc;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL commit_with_done cycle=%0d actual_done=%0b required=0", cyc, done);
            end
        end
        if (done && !done_q) done_rise_cyc = cyc;
        done_q = done;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(s_ready), 32'd1);
    endtask

    // Present a word and return the cycle in which the handshake happened
    task automatic offer(input logic [7:0] w, input string name, output int acc_cyc);
        s_valid = 1'b1;
        s_data  = w;
        wait_ready(name);
        acc_cyc = cyc;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                                input int stall, input bit mid, input logic [7:0] cs,
                                input logic [19:0] bits, input bit err);
        vec_t v;
        v.words     = {w2, w1, w0};
        v.stall     = stall;
        v.start_mid = mid;
        v.csum      = cs;
        v.exp_bits  = bits;
        v.exp_err   = err;
        return v;
    endfunction

    task automatic run_load(input vec_t v);
        int acc;
        int base_commit;
        int n;
        logic exp_err;
        exp_err = CSUM_EN & v.exp_err;
        base_commit = commit_cnt;
        for (int i = 0; i < 20; i++) exp_q.push_back(v.exp_bits[i]);
        pulse_start();
        check("start_state", 32'({s_ready, busy, done, error}), 32'b1100);
        for (int w = 0; w < 3; w++) begin
            offer(v.words[w], "word_ready", acc);
            if (w == 0) begin
                if (v.start_mid) begin
                    pulse_start();
                    check("start_mid_ignored", 32'({busy, cfg_shift_en, s_ready}), 32'b110);
                end
                wait_ready("word_gap");
                check("ready_latency", 32'(cyc - acc), 32'(WW + 1));
            end
            if (w < 2 && v.stall > 0) begin
                wait_ready("stall_ready");
                for (int s = 0; s < v.stall; s++) begin
                    check("stall_hold", 32'({s_ready, cfg_shift_en}), 32'b10);
                    tick();
                end
            end
        end
`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
        offer(v.csum, "csum_ready", acc);
`endif
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("done", 32'(done), 32'd1);
        check("error", 32'(error), 32'(exp_err));
        check("busy_idle", 32'(busy), 32'd0);
        check("commit_count", 32'(commit_cnt - base_commit), exp_err ? 32'd0 : 32'd1);
        check("bits_left", 32'(exp_q.size()), 32'd0);
`ifdef CONFIG_CHAIN_LOADER_CHECKSUM_EN
        if (exp_err) check("err_latency", 32'(done_rise_cyc - acc), 32'd1);
        else         check("commit_latency", 32'(commit_cyc - acc), 32'd1);
`else
        check("commit_latency", 32'(commit_cyc - last_shift_cyc), 32'd1);
        check("done_latency", 32'(done_rise_cyc - commit_cyc), 32'd1);
`endif
        exp_q.delete();
    endtask

    initial begin
        int acc;
        int base;
        int base_commit;
        int n;
        int widx;
        int nw;
        int nshift;
        int c2;
        bit hs;
        logic [15:0] exp16;
        logic [7:0] fw [3];

        vecs[0] = mk(8'hA5, 8'h3C, 8'hF9, 0, 1'b0, 8'h60, 20'h93CA5, 1'b0);
        vecs[1] = mk(8'hA5, 8'h3C, 8'hF9, 5, 1'b0, 8'h60, 20'h93CA5, 1'b0);
        vecs[2] = mk(8'hA5, 8'h3C, 8'hF9, 0, 1'b0, 8'h61, 20'h93CA5, 1'b1);
        vecs[3] = mk(8'h00, 8'hFF, 8'h0F, 0, 1'b1, 8'hF0, 20'hFFF00, 1'b0);
        vecs[4] = mk(8'h12, 8'h34, 8'h56, 2, 1'b0, 8'h70, 20'h63412, 1'b0);
        vecs[5] = mk(8'hFF, 8'hFF, 8'hF0, 1, 1'b0, 8'hF0, 20'h0FFFF, 1'b0);

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        start2 = 1'b0; s_valid2 = 1'b0; s_data2 = 8'h00;
        tick(); tick(); tick();
        check("reset_outputs", 32'({s_ready, cfg_shift_data, cfg_shift_en, cfg_commit, busy, done, error}), 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_idle", 32'({s_ready, cfg_shift_en, cfg_commit, busy, done, error}), 32'd0);

        for (int i = 0; i < 6; i++) run_load(vecs[i]);

        // Words offered while in DONE must not be consumed
        s_valid = 1'b1;
        s_data  = 8'h77;
        for (int k = 0; k < 5; k++) begin
            check("done_no_consume", 32'({s_ready, cfg_shift_en, done}), 32'b001);
            tick();
        end
        s_valid = 1'b0;

        // Reset after the 10th shift abandons the load without a commit
        base_commit = commit_cnt;
        for (int i = 0; i < 20; i++) exp_q.push_back(vecs[0].exp_bits[i]);
        pulse_start();
        base = shift_total;
        offer(8'hA5, "rst_w0", acc);
        offer(8'h3C, "rst_w1", acc);
        n = 0;
        while ((shift_total - base) < 10 && n < 50) begin
            tick();
            n++;
        end
        check("rst_shift_count", 32'(shift_total - base), 32'd10);
        rst = 1'b1;
        tick();
        check("rst_mid_outputs", 32'({s_ready, cfg_shift_data, cfg_shift_en, cfg_commit, busy, done, error}), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_mid_idle", 32'({s_ready, cfg_shift_en, busy, done}), 32'd0);
        check("rst_no_commit", 32'(commit_cnt - base_commit), 32'd0);
        exp_q.delete();
        run_load(vecs[0]);

        // Exact-fit chain with s_valid held high throughout
        exp16 = 16'hC35A;
        fw[0] = 8'h5A; fw[1] = 8'hC3; fw[2] = 8'h99;
        nw = CSUM_EN ? 3 : 2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("fit_ready", 32'(s_ready2), 32'd1);
        widx = 0; nshift = 0; c2 = 0;
        s_valid2 = 1'b1;
        s_data2  = fw[0];
        for (int k = 0; k < 80 && !done2; k++) begin
            if (cfg_shift_en2) begin
                if (nshift < 16) check("fit_bit", 32'(cfg_shift_data2), 32'(exp16[nshift]));
                nshift++;
            end
            if (cfg_commit2) c2++;
            hs = s_ready2 && s_valid2;
            tick();
            if (hs) begin
                widx++;
                if (widx < nw) s_data2 = fw[widx];
                else           s_valid2 = 1'b0;
            end
        end
        s_valid2 = 1'b0;
        check("fit_shift_count", 32'(nshift), 32'd16);
        check("fit_commit_count", 32'(c2), 32'd1);
        check("fit_done", 32'({done2, error2, busy2}), 32'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
